// File: rtl/branch_pc_sequencer.sv
// Program-counter owner and fetch sequencer around the branch comparator.
// Chooses the next PC (sequential, redirect or hold), pulses flush for one
// cycle on every redirect, halts on a misaligned taken target, and keeps
// saturating counters of accepted control transfers.
//
// Handshake: a fetch is accepted on a rising edge when the sequencer is in
// S_FETCH, imem_ready_i is high and stall_i is low. br_* inputs are sampled
// only on such an accept. stall_i has priority over imem_ready_i.
module branch_pc_sequencer #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             imem_ready_i,
  input  logic             br_valid_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  br_target_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             imem_req_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_FETCH    = 2'd1,
    S_REDIRECT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_next;
  logic             r_misalign;
  logic             w_misalign_next;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] w_br_cnt_next;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] w_taken_cnt_next;

  logic w_accept;
  logic w_take;
  logic w_aligned;

  assign w_accept  = (r_state == S_FETCH) & imem_ready_i & ~stall_i;
  assign w_take    = w_accept & br_valid_i & br_taken_i;
  assign w_aligned = (br_target_i[1:0] == 2'b00);

  // State register: reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_state_next;
  end

  // Next-state decode: one dead boot cycle, redirect lasts exactly one cycle,
  // halt is only left through reset.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_BOOT:     w_state_next = S_FETCH;
      S_FETCH:    if (w_take) w_state_next = w_aligned ? S_REDIRECT : S_HALT;
      S_REDIRECT: w_state_next = S_FETCH;
      S_HALT:     w_state_next = S_HALT;
      default:    w_state_next = S_BOOT;
    endcase
  end

  // Moore outputs decoded from state only.
  always_comb begin
    imem_req_o = 1'b0;
    flush_o    = 1'b0;
    case (r_state)
      S_FETCH:    imem_req_o = 1'b1;
      S_REDIRECT: begin
        imem_req_o = 1'b1;
        flush_o    = 1'b1;
      end
      default: begin
        imem_req_o = 1'b0;
        flush_o    = 1'b0;
      end
    endcase
  end

  // Datapath next values: PC select, sticky misalign, saturating counters.
  always_comb begin
    w_pc_next        = r_pc;
    w_misalign_next  = r_misalign;
    w_br_cnt_next    = r_br_cnt;
    w_taken_cnt_next = r_taken_cnt;
    if (w_accept) begin
      if (w_take) begin
        if (w_aligned) w_pc_next = br_target_i;
        else           w_misalign_next = 1'b1;
      end else begin
        // Modulo 2^XLEN: wrap past the top of the address space is silent.
        w_pc_next = r_pc + XLEN'(PC_STEP);
      end
      if (br_valid_i && (r_br_cnt != {CNT_W{1'b1}}))
        w_br_cnt_next = r_br_cnt + 1'b1;
      if (w_take && (r_taken_cnt != {CNT_W{1'b1}}))
        w_taken_cnt_next = r_taken_cnt + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_misalign  <= 1'b0;
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_pc        <= w_pc_next;
      r_misalign  <= w_misalign_next;
      r_br_cnt    <= w_br_cnt_next;
      r_taken_cnt <= w_taken_cnt_next;
    end
  end

  assign pc_o        = r_pc;
  assign misalign_o  = r_misalign;
  assign br_cnt_o    = r_br_cnt;
  assign taken_cnt_o = r_taken_cnt;
  assign state_o     = r_state;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed bench for branch_pc_sequencer. A second instance with 3-bit
// counters shares all inputs so saturation is reachable in a few branches.
module tb_branch_pc_sequencer;

  localparam logic [1:0] S_BOOT = 2'd0, S_FETCH = 2'd1, S_REDIRECT = 2'd2, S_HALT = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, imem_ready_i, br_valid_i, br_taken_i;
  logic [31:0] br_target_i;
  logic [31:0] pc_o, pc_s;
  logic        imem_req_o, flush_o, misalign_o;
  logic        req_s, flush_s, mis_s;
  logic [15:0] br_cnt_o, taken_cnt_o;
  logic [2:0]  br_cnt_s, taken_cnt_s;
  logic [1:0]  state_o, state_s;

  int checks   = 0;
  int failures = 0;

  // Clock
  always #5 clk = ~clk;

  branch_pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .imem_ready_i(imem_ready_i),
    .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .pc_o(pc_o), .imem_req_o(imem_req_o), .flush_o(flush_o), .misalign_o(misalign_o),
    .br_cnt_o(br_cnt_o), .taken_cnt_o(taken_cnt_o), .state_o(state_o)
  );

  branch_pc_sequencer #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .imem_ready_i(imem_ready_i),
    .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .pc_o(pc_s), .imem_req_o(req_s), .flush_o(flush_s), .misalign_o(mis_s),
    .br_cnt_o(br_cnt_s), .taken_cnt_o(taken_cnt_s), .state_o(state_s)
  );

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic v, input logic t, input logic [31:0] tgt);
    br_valid_i  = v;
    br_taken_i  = t;
    br_target_i = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b1; set_br(1'b0, 1'b0, 32'h0);
    tick(); tick();
    checks++; if (state_o !== S_BOOT) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", state_o, S_BOOT); end
    checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc_o, 32'h0); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req_o); end
    checks++; if (flush_o !== 1'b0 || misalign_o !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", flush_o, misalign_o); end
    checks++; if (br_cnt_o !== 16'h0 || taken_cnt_o !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%h/%h exp=0/0", br_cnt_o, taken_cnt_o); end
    rst_n = 1'b1;
    tick();
    checks++; if (state_o !== S_FETCH || imem_req_o !== 1'b1 || pc_o !== 32'h0) begin failures++; $display("FAIL boot_exit got st=%0d req=%b pc=%h exp st=1 req=1 pc=0", state_o, imem_req_o, pc_o); end
    tick();
    checks++; if (pc_o !== 32'h4) begin failures++; $display("FAIL seq_pc4 got=%h exp=%h", pc_o, 32'h4); end
    tick();
    checks++; if (pc_o !== 32'h8) begin failures++; $display("FAIL seq_pc8 got=%h exp=%h", pc_o, 32'h8); end
  endtask

  task automatic test_stall_ready();
    tick(); tick();
    checks++; if (pc_o !== 32'h10) begin failures++; $display("FAIL pre_stall_pc got=%h exp=%h", pc_o, 32'h10); end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_o !== 32'h10 || imem_req_o !== 1'b1) begin failures++; $display("FAIL stall_hold got pc=%h req=%b exp pc=10 req=1", pc_o, imem_req_o); end
    end
    stall_i = 1'b0; imem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_o !== 32'h10) begin failures++; $display("FAIL notready_hold got=%h exp=%h", pc_o, 32'h10); end
    end
    imem_ready_i = 1'b1;
  endtask

  task automatic test_taken();
    for (int i = 0; i < 4; i++) tick();
    checks++; if (pc_o !== 32'h20) begin failures++; $display("FAIL pre_br_pc got=%h exp=%h", pc_o, 32'h20); end
    set_br(1'b1, 1'b1, 32'h100);
    tick();
    checks++; if (pc_o !== 32'h100 || flush_o !== 1'b1 || state_o !== S_REDIRECT) begin failures++; $display("FAIL taken_redir got pc=%h fl=%b st=%0d exp pc=100 fl=1 st=2", pc_o, flush_o, state_o); end
    checks++; if (br_cnt_o !== 16'd1 || taken_cnt_o !== 16'd1) begin failures++; $display("FAIL taken_cnt got=%0d/%0d exp=1/1", br_cnt_o, taken_cnt_o); end
    // Branch inputs left asserted: the redirect cycle must not accept them.
    set_br(1'b1, 1'b1, 32'h200);
    tick();
    checks++; if (pc_o !== 32'h100 || flush_o !== 1'b0 || state_o !== S_FETCH) begin failures++; $display("FAIL redir_noacc got pc=%h fl=%b st=%0d exp pc=100 fl=0 st=1", pc_o, flush_o, state_o); end
    checks++; if (br_cnt_o !== 16'd1 || taken_cnt_o !== 16'd1) begin failures++; $display("FAIL redir_cnt got=%0d/%0d exp=1/1", br_cnt_o, taken_cnt_o); end
    set_br(1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (pc_o !== 32'h104) begin failures++; $display("FAIL target_seq got=%h exp=%h", pc_o, 32'h104); end
  endtask

  task automatic test_not_taken();
    set_br(1'b1, 1'b0, 32'h500);
    tick();
    checks++; if (pc_o !== 32'h108 || flush_o !== 1'b0) begin failures++; $display("FAIL nt_pc got pc=%h fl=%b exp pc=108 fl=0", pc_o, flush_o); end
    checks++; if (br_cnt_o !== 16'd2 || taken_cnt_o !== 16'd1) begin failures++; $display("FAIL nt_cnt got=%0d/%0d exp=2/1", br_cnt_o, taken_cnt_o); end
    set_br(1'b0, 1'b1, 32'h300);
    tick();
    checks++; if (pc_o !== 32'h10C || state_o !== S_FETCH) begin failures++; $display("FAIL inval_pc got pc=%h st=%0d exp pc=10c st=1", pc_o, state_o); end
    checks++; if (br_cnt_o !== 16'd2 || taken_cnt_o !== 16'd1) begin failures++; $display("FAIL inval_cnt got=%0d/%0d exp=2/1", br_cnt_o, taken_cnt_o); end
    set_br(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_stall_in_redirect();
    set_br(1'b1, 1'b1, 32'h200);
    tick();
    set_br(1'b0, 1'b0, 32'h0);
    stall_i = 1'b1;
    tick();
    checks++; if (flush_o !== 1'b0 || state_o !== S_FETCH || pc_o !== 32'h200) begin failures++; $display("FAIL stall_redir got fl=%b st=%0d pc=%h exp fl=0 st=1 pc=200", flush_o, state_o, pc_o); end
    tick();
    checks++; if (pc_o !== 32'h200) begin failures++; $display("FAIL stall_after_redir got=%h exp=%h", pc_o, 32'h200); end
    stall_i = 1'b0;
    tick();
    checks++; if (pc_o !== 32'h204 || br_cnt_o !== 16'd3 || taken_cnt_o !== 16'd2) begin failures++; $display("FAIL post_redir got pc=%h cnt=%0d/%0d exp pc=204 cnt=3/2", pc_o, br_cnt_o, taken_cnt_o); end
  endtask

  task automatic test_wrap();
    set_br(1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    set_br(1'b0, 1'b0, 32'h0);
    checks++; if (pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre got=%h exp=%h", pc_o, 32'hFFFF_FFFC); end
    tick(); tick();
    checks++; if (pc_o !== 32'h0 || misalign_o !== 1'b0) begin failures++; $display("FAIL wrap_zero got pc=%h mis=%b exp pc=0 mis=0", pc_o, misalign_o); end
    tick();
    checks++; if (pc_o !== 32'h4) begin failures++; $display("FAIL wrap_next got=%h exp=%h", pc_o, 32'h4); end
  endtask

  task automatic test_back_to_back_saturate();
    // Counters now 4/3 on both instances; six more taken branches.
    for (int i = 0; i < 6; i++) begin
      set_br(1'b1, 1'b1, 32'h1000);
      tick();
      set_br(1'b0, 1'b0, 32'h0);
      tick();
    end
    set_br(1'b1, 1'b0, 32'h0);
    tick();
    set_br(1'b0, 1'b0, 32'h0);
    checks++; if (br_cnt_o !== 16'd11 || taken_cnt_o !== 16'd9) begin failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=11/9", br_cnt_o, taken_cnt_o); end
    checks++; if (br_cnt_s !== 3'd7 || taken_cnt_s !== 3'd7) begin failures++; $display("FAIL sat_cnt got=%0d/%0d exp=7/7", br_cnt_s, taken_cnt_s); end
    checks++; if (pc_o !== 32'h1004) begin failures++; $display("FAIL b2b_pc got=%h exp=%h", pc_o, 32'h1004); end
  endtask

  task automatic test_reset_in_redirect();
    set_br(1'b1, 1'b1, 32'h80);
    tick();
    checks++; if (state_o !== S_REDIRECT || flush_o !== 1'b1) begin failures++; $display("FAIL pre_rst_redir got st=%0d fl=%b exp st=2 fl=1", state_o, flush_o); end
    rst_n = 1'b0;
    tick();
    checks++; if (state_o !== S_BOOT || flush_o !== 1'b0 || imem_req_o !== 1'b0 || pc_o !== 32'h0) begin failures++; $display("FAIL rst_redir got st=%0d fl=%b req=%b pc=%h exp st=0 fl=0 req=0 pc=0", state_o, flush_o, imem_req_o, pc_o); end
    checks++; if (br_cnt_o !== 16'd0 || taken_cnt_o !== 16'd0) begin failures++; $display("FAIL rst_redir_cnt got=%0d/%0d exp=0/0", br_cnt_o, taken_cnt_o); end
    set_br(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_misalign();
    tick(); tick();
    checks++; if (pc_o !== 32'h4) begin failures++; $display("FAIL mis_pre got=%h exp=%h", pc_o, 32'h4); end
    set_br(1'b1, 1'b1, 32'h102);
    tick();
    checks++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || state_o !== S_HALT || pc_o !== 32'h4) begin failures++; $display("FAIL mis_halt got mis=%b req=%b st=%0d pc=%h exp mis=1 req=0 st=3 pc=4", misalign_o, imem_req_o, state_o, pc_o); end
    checks++; if (br_cnt_o !== 16'd1 || taken_cnt_o !== 16'd1 || flush_o !== 1'b0) begin failures++; $display("FAIL mis_cnt got=%0d/%0d fl=%b exp=1/1 fl=0", br_cnt_o, taken_cnt_o, flush_o); end
    set_br(1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_o !== 32'h4 || misalign_o !== 1'b1 || br_cnt_o !== 16'd1 || state_o !== S_HALT) begin failures++; $display("FAIL mis_frozen got pc=%h mis=%b cnt=%0d st=%0d exp pc=4 mis=1 cnt=1 st=3", pc_o, misalign_o, br_cnt_o, state_o); end
    end
    set_br(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    tick();
    checks++; if (pc_o !== 32'h0 || misalign_o !== 1'b0 || state_o !== S_BOOT) begin failures++; $display("FAIL mis_clear got pc=%h mis=%b st=%0d exp pc=0 mis=0 st=0", pc_o, misalign_o, state_o); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stall_ready();
    test_taken();
    test_not_taken();
    test_stall_in_redirect();
    test_wrap();
    test_back_to_back_saturate();
    test_reset_in_redirect();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
